// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster constants and the
// registered output bundle shared by the VGA blocks.
package vga_pkg;

  localparam int unsigned CLK_DIV_DEF = 4;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_HS_START =
    VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_HS_END =
    VGA_HS_START + VGA_H_SYNC;
  localparam int unsigned VGA_VS_START =
    VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_VS_END =
    VGA_VS_START + VGA_V_SYNC;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_tick;
    logic       frame_tick;
  } vga_out_t;

endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: pixel-enable strobe generator.
// adv_o marks the edge that registers pix_en_o.
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic pix_en_o,
  output logic adv_o
);

  localparam int unsigned W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_pix_div: CLK_DIV must be >= 2");
  end

  logic [W-1:0] div_q, div_d;
  logic         pix_en_q;

  assign adv_o    = en_i && (div_q == LAST);
  assign pix_en_o = pix_en_q;

  always_comb begin
    div_d = div_q + W'(1);
    if (!en_i || adv_o) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= adv_o;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered VGA raster timing driven
// by a pixel-enable strobe from the system clock.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int unsigned HT =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HT > 1024 || VT > 1024) begin : g_bad_total
    $error("vga_timing_gen: totals exceed 10 bits");
  end

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END =
    10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END =
    10'(V_ACTIVE + V_FP + V_SYNC);

  localparam vga_out_t IDLE = '{
    hsync:      ~HS_POL,
    vsync:      ~VS_POL,
    video_on:   1'b0,
    x:          10'd0,
    y:          10'd0,
    line_tick:  1'b0,
    frame_tick: 1'b0
  };

  logic       adv;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  vga_out_t   out_q, out_d;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk_i    (clk),
    .rst_ni   (rst),
    .en_i     (en),
    .pix_en_o (pix_en),
    .adv_o    (adv)
  );

  // Outputs present the pre-increment pixel.
  always_comb begin
    h_d              = h_q;
    v_d              = v_q;
    out_d            = out_q;
    out_d.line_tick  = 1'b0;
    out_d.frame_tick = 1'b0;
    if (!en) begin
      h_d   = '0;
      v_d   = '0;
      out_d = IDLE;
    end else if (adv) begin
      out_d.hsync =
        (h_q >= HS_BEG && h_q < HS_END) ?
        HS_POL : ~HS_POL;
      out_d.vsync =
        (v_q >= VS_BEG && v_q < VS_END) ?
        VS_POL : ~VS_POL;
      out_d.video_on =
        (h_q < H_VIS) && (v_q < V_VIS);
      out_d.x          = h_q;
      out_d.y          = v_q;
      out_d.line_tick  = (h_q == '0);
      out_d.frame_tick =
        (h_q == '0) && (v_q == V_VIS);
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q   <= '0;
      v_q   <= '0;
      out_q <= IDLE;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      out_q <= out_d;
    end
  end

  assign hsync      = out_q.hsync;
  assign vsync      = out_q.vsync;
  assign video_on   = out_q.video_on;
  assign x          = out_q.x;
  assign y          = out_q.y;
  assign line_tick  = out_q.line_tick;
  assign frame_tick = out_q.frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: cycle-accurate check of a reduced
// raster against an elapsed-cycle arithmetic model.
module tb_vga_timing_gen;

  localparam int CD = 4;
  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VA = 10;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int HSS = HA + HF;
  localparam int VSS = VA + VF;
  localparam int LINE = HT * CD;
  localparam int FRAME = LINE * VT;
  localparam logic [25:0] IDLE =
    {1'b0, 1'b1, 1'b1, 1'b0, 20'd0, 2'b00};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic pix_en, hsync, vsync, video_on;
  logic line_tick, frame_tick;
  logic [9:0] x, y;
  logic [25:0] obs;

  int c, n_assert, n_fail;
  int hs_run, vs_run, last_lt, last_ft, ft_cnt;
  logic hs_prev, vs_prev;

  vga_timing_gen #(
    .CLK_DIV (CD),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL  (1'b0),
    .VS_POL  (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pix_en    (pix_en),
    .hsync     (hsync),
    .vsync     (vsync),
    .video_on  (video_on),
    .x         (x),
    .y         (y),
    .line_tick (line_tick),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  assign obs = {pix_en, hsync, vsync, video_on,
                x, y, line_tick, frame_tick};

  // cc = clock edges since the raster was released.
  function automatic logic [25:0] model(input int cc);
    int p, ph, h, v;
    logic [9:0] hx, vy;
    if (cc < CD) return IDLE;
    p  = (cc - CD) / CD;
    ph = (cc - CD) % CD;
    h  = p % HT;
    v  = (p / HT) % VT;
    hx = 10'(h);
    vy = 10'(v);
    return {ph == 0,
            !(h >= HSS && h < HSS + HS),
            !(v >= VSS && v < VSS + VS),
            (h < HA && v < VA),
            hx, vy,
            (ph == 0 && h == 0),
            (ph == 0 && h == 0 && v == VA)};
  endfunction

  function automatic int pix_c(input int f, input int h,
                               input int v);
    return CD * (1 + f * HT * VT + v * HT + h);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s c=%0d observed=%h expected=%h",
             tag, c, o, e);
    end
  endtask

  task automatic reset_track();
    hs_run = 0;
    vs_run = 0;
    last_lt = -1;
    last_ft = -1;
    hs_prev = 1'b1;
    vs_prev = 1'b1;
  endtask

  task automatic track();
    if (c == 0) begin
      reset_track();
      return;
    end
    if (!hsync) begin
      if (hs_prev) chk("hs_start_x", 32'(x), HSS);
      hs_run++;
    end else if (!hs_prev) begin
      chk("hs_width", hs_run, HS * CD);
      hs_run = 0;
    end
    hs_prev = hsync;
    if (!vsync) begin
      if (vs_prev) chk("vs_start", {x, y}, {10'd0, 10'(VSS)});
      vs_run++;
    end else if (!vs_prev) begin
      chk("vs_width", vs_run, VS * LINE);
      vs_run = 0;
    end
    vs_prev = vsync;
    if (line_tick) begin
      chk("lt_x", 32'(x), 0);
      if (last_lt >= 0) chk("lt_period", c - last_lt, LINE);
      last_lt = c;
    end
    if (frame_tick) begin
      ft_cnt++;
      chk("ft_pos", {x, y}, {10'd0, 10'(VA)});
      if (last_ft >= 0) chk("ft_period", c - last_ft, FRAME);
      last_ft = c;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst || !en) c = 0;
    else c++;
    @(negedge clk);
    chk("cycle", obs, model(c));
    track();
  endtask

  task automatic run_to(input int target);
    int g;
    g = 0;
    while (c < target && g < 20000) begin
      step();
      g++;
    end
    chk("run_to", c, target);
  endtask

  task automatic check_start();
    run_to(CD - 1);
    chk("pre_pix", 32'(pix_en), 0);
    step();
    chk("first_pix", {pix_en, video_on, x, y},
        {1'b1, 1'b1, 20'd0});
  endtask

  task automatic async_reset(input int dly);
    #(dly) rst = 1'b0;
    #1;
    c = 0;
    chk("rst_async", obs, IDLE);
    reset_track();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog c=%0d", c);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    n_assert = 0;
    n_fail = 0;
    c = 0;
    ft_cnt = 0;
    reset_track();
    rst = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", obs, IDLE);
    repeat (3) step();
    rst = 1'b1;

    check_start();
    ft_cnt = 0;
    run_to(2 * FRAME + CD);
    chk("ft_count", ft_cnt, 2);
    chk("wrap", {x, y, line_tick, frame_tick, video_on},
        {20'd0, 3'b101});

    run_to(pix_c(2, 10, 5));
    chk("en_drop_pos", {x, y}, {10'd10, 10'd5});
    en = 1'b0;
    step();
    chk("en_idle", obs, IDLE);
    repeat (9) step();
    en = 1'b1;
    check_start();

    run_to(pix_c(0, 7, VSS + 1));
    chk("mid_vsync", {vsync, y}, {1'b0, 10'(VSS + 1)});
    async_reset(1);
    chk("rst_vs_ticks", {vsync, line_tick, frame_tick},
        3'b100);
    repeat (3) step();
    rst = 1'b1;
    check_start();
    run_to(FRAME + CD + LINE);

    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(20, 900);
      repeat (n) step();
      if ($urandom_range(0, 1) == 1) begin
        en = 1'b0;
        repeat ($urandom_range(1, 12)) step();
        en = 1'b1;
      end else begin
        async_reset($urandom_range(1, 3));
        repeat ($urandom_range(1, 5)) step();
        rst = 1'b1;
      end
      check_start();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
